// File: rtl/lift_scan_if.sv
// Request and status bundle between the request decoder, the SCAN controller and
// the motor/door drivers.
interface lift_scan_if #(
   parameter int FLOORS = 8
) ();
   localparam int FLOOR_W = $clog2(FLOORS);

   logic               req_valid;
   logic [FLOOR_W-1:0] req_floor;
   logic               emergency_stop;
   logic               req_reject;
   logic [FLOORS-1:0]  pending;
   logic [FLOOR_W-1:0] current_floor;
   logic               dir_up;
   logic               dir_down;
   logic               moving;
   logic               door_open;
   logic               idle;
   logic               estop_active;

   modport master (
      output req_valid, req_floor, emergency_stop,
      input  req_reject, pending, current_floor, dir_up, dir_down,
             moving, door_open, idle, estop_active
   );

   modport slave (
      input  req_valid, req_floor, emergency_stop,
      output req_reject, pending, current_floor, dir_up, dir_down,
             moving, door_open, idle, estop_active
   );
endinterface

// File: rtl/lift_scan_ctrl.sv
// Single-car SCAN elevator controller: pending-request bitmap, travel/door timers, e-stop.
// Optional idle parking to PARK_FLOOR when LIFT_PARKING_EN is defined.
module lift_scan_ctrl #(
   parameter int FLOORS        = 8,
   parameter int TRAVEL_CYCLES = 2,
   parameter int DOOR_CYCLES   = 3,
   parameter int PARK_FLOOR    = 0,
   parameter int PARK_CYCLES   = 16
) (
   input logic       clk,
   input logic       reset,
   lift_scan_if.slave bus
);
   localparam int FLOOR_W = $clog2(FLOORS);
   localparam int TW      = $clog2(TRAVEL_CYCLES + 1);
   localparam int DW      = $clog2(DOOR_CYCLES + 1);

   typedef enum logic [1:0] {S_IDLE, S_MOVE, S_DOOR, S_ESTOP} state_t;

   state_t             state, state_n;
   logic [FLOORS-1:0]  pending, pending_n, set_mask, clr_mask;
   logic [FLOORS-1:0]  above, below, beyond;
   logic [FLOOR_W-1:0] cur, cur_n, nf;
   logic               up, up_n, dn, dn_n;
   logic [TW-1:0]      tcnt, tcnt_n;
   logic [DW-1:0]      dcnt, dcnt_n;
   logic               reject, reject_n;
   logic               parking, parking_n, park_go;
   logic               any_above, any_below, at_end, reload;
   logic               travel_done, door_done;

   assign travel_done = (tcnt == TW'(TRAVEL_CYCLES - 1));
   assign door_done   = (dcnt == DW'(DOOR_CYCLES - 1));
   assign any_above   = |(pending & above);
   assign any_below   = |(pending & below);
   assign nf          = up ? cur + FLOOR_W'(1) : cur - FLOOR_W'(1);
   assign at_end      = up ? (cur == FLOOR_W'(FLOORS - 1)) : (cur == '0);
   // A repeat call for the floor whose door is open extends the dwell instead of re-latching.
   assign reload      = bus.req_valid && (state == S_DOOR) && (bus.req_floor == cur) &&
                        !bus.emergency_stop;

`ifdef LIFT_PARKING_EN
   localparam int IW = $clog2(PARK_CYCLES + 1);
   logic [IW-1:0] idle_cnt;
   logic          idle_full;

   assign idle_full = (idle_cnt == IW'(PARK_CYCLES - 1));
   assign park_go   = idle_full && (pending == '0) && (cur != FLOOR_W'(PARK_FLOOR));

   always_ff @(posedge clk) begin
      if (reset || state != S_IDLE || pending != '0 || bus.emergency_stop)
         idle_cnt <= '0;
      else if (!idle_full)
         idle_cnt <= idle_cnt + IW'(1);
   end
`else
   // Parking disabled: the car never leaves IDLE unprompted.
   assign park_go = 1'b0 & (PARK_CYCLES > 0);
`endif

   always_comb begin
      above    = '0;
      below    = '0;
      beyond   = '0;
      set_mask = '0;
      for (int i = 0; i < FLOORS; i++) begin
         above[i]    = (i > int'(cur));
         below[i]    = (i < int'(cur));
         beyond[i]   = up ? (i > int'(nf)) : (i < int'(nf));
         set_mask[i] = bus.req_valid && (int'(bus.req_floor) == i);
      end
   end

   always_comb begin
      state_n   = state;
      cur_n     = cur;
      up_n      = up;
      dn_n      = dn;
      tcnt_n    = '0;
      dcnt_n    = '0;
      clr_mask  = '0;
      parking_n = parking;
      reject_n  = bus.req_valid && (int'(bus.req_floor) >= FLOORS);

      case (state)
         S_IDLE: begin
            parking_n = 1'b0;
            if (pending[cur]) begin
               state_n  = S_DOOR;
               clr_mask = FLOORS'(1) << cur;
            end else if (any_above) begin
               state_n = S_MOVE;
               up_n    = 1'b1;
               dn_n    = 1'b0;
            end else if (any_below) begin
               state_n = S_MOVE;
               up_n    = 1'b0;
               dn_n    = 1'b1;
            end else begin
               up_n = 1'b0;
               dn_n = 1'b0;
               if (park_go) begin
                  state_n   = S_MOVE;
                  parking_n = 1'b1;
                  up_n      = (FLOOR_W'(PARK_FLOOR) > cur);
                  dn_n      = (FLOOR_W'(PARK_FLOOR) < cur);
               end
            end
         end
         S_MOVE: begin
            tcnt_n = tcnt + TW'(1);
            if ((!up && !dn) || at_end) begin
               state_n   = S_IDLE;
               up_n      = 1'b0;
               dn_n      = 1'b0;
               parking_n = 1'b0;
               tcnt_n    = '0;
            end else if (travel_done) begin
               tcnt_n = '0;
               cur_n  = nf;
               if (pending[nf]) begin
                  state_n   = S_DOOR;
                  clr_mask  = FLOORS'(1) << nf;
                  parking_n = 1'b0;
               end else if (!(|(pending & beyond)) &&
                            !(parking && nf != FLOOR_W'(PARK_FLOOR))) begin
                  state_n   = S_IDLE;
                  up_n      = 1'b0;
                  dn_n      = 1'b0;
                  parking_n = 1'b0;
               end
            end
         end
         S_DOOR: begin
            parking_n = 1'b0;
            if (reload)
               dcnt_n = '0;
            else if (!door_done)
               dcnt_n = dcnt + DW'(1);
            else if (dn ? any_below : any_above) begin
               state_n = S_MOVE;
               up_n    = !dn;
               dn_n    = dn;
            end else if (dn ? any_above : any_below) begin
               state_n = S_MOVE;
               up_n    = dn;
               dn_n    = !dn;
            end else begin
               state_n = S_IDLE;
               up_n    = 1'b0;
               dn_n    = 1'b0;
            end
         end
         S_ESTOP: begin
            if (!bus.emergency_stop)
               state_n = S_IDLE;
         end
         default: state_n = S_IDLE;
      endcase

      // E-stop freezes position and direction; only the request latch keeps running.
      if (bus.emergency_stop) begin
         state_n   = S_ESTOP;
         cur_n     = cur;
         up_n      = up;
         dn_n      = dn;
         tcnt_n    = '0;
         dcnt_n    = '0;
         clr_mask  = '0;
         parking_n = 1'b0;
      end

      pending_n = (pending | (reload ? '0 : set_mask)) & ~clr_mask;
   end

   always_ff @(posedge clk) begin
      if (reset) begin
         state   <= S_IDLE;
         cur     <= '0;
         pending <= '0;
         up      <= 1'b0;
         dn      <= 1'b0;
         tcnt    <= '0;
         dcnt    <= '0;
         reject  <= 1'b0;
         parking <= 1'b0;
      end else begin
         state   <= state_n;
         cur     <= cur_n;
         pending <= pending_n;
         up      <= up_n;
         dn      <= dn_n;
         tcnt    <= tcnt_n;
         dcnt    <= dcnt_n;
         reject  <= reject_n;
         parking <= parking_n;
      end
   end

   assign bus.req_reject    = reject;
   assign bus.pending       = pending;
   assign bus.current_floor = cur;
   assign bus.dir_up        = up;
   assign bus.dir_down      = dn;
   assign bus.moving        = (state == S_MOVE);
   assign bus.door_open     = (state == S_DOOR);
   assign bus.idle          = (state == S_IDLE);
   assign bus.estop_active  = (state == S_ESTOP);
endmodule

// File: tb/tb_lift_scan_ctrl.sv
// Scoreboard bench for lift_scan_ctrl: stimulus queues expected car events (steps, door
// open/close, idle, e-stop); a negedge monitor pops and compares them as the car produces them.
module tb_lift_scan_ctrl;
   localparam int TC = 2;
   localparam int DC = 3;

   logic clk = 1'b0;
   logic reset;
   always #5 clk = ~clk;

   lift_scan_if #(.FLOORS(8)) bus ();
   lift_scan_if #(.FLOORS(6)) bus6 ();

   lift_scan_ctrl #(.FLOORS(8), .TRAVEL_CYCLES(TC), .DOOR_CYCLES(DC),
                    .PARK_FLOOR(0), .PARK_CYCLES(16))
      dut (.clk(clk), .reset(reset), .bus(bus));

   lift_scan_ctrl #(.FLOORS(6), .TRAVEL_CYCLES(TC), .DOOR_CYCLES(DC),
                    .PARK_FLOOR(0), .PARK_CYCLES(16))
      dut6 (.clk(clk), .reset(reset), .bus(bus6));

   typedef enum int {EV_STEP, EV_DOPEN, EV_DCLOSE, EV_IDLE, EV_ESTOP} ev_kind_t;
   typedef struct {
      ev_kind_t kind;
      int       floor;
      int       dirs;   // {dir_up, dir_down}
      int       span;   // step interval or door-open duration, in cycles
   } ev_t;

   ev_t exp_q[$];
   int  errors = 0;
   int  checks = 0;

   task automatic chk(string name, int act, int req);
      checks++;
      if (act != req) begin
         errors++;
         $display("FAIL %s: got %0d, required %0d", name, act, req);
      end
   endtask

   task automatic push(ev_kind_t k, int f, int d, int s);
      ev_t e;
      e.kind = k; e.floor = f; e.dirs = d; e.span = s;
      exp_q.push_back(e);
   endtask

   task automatic push_steps(int from, int to);
      int f;
      int d;
      f = from;
      d = (to > from) ? 2 : 1;
      while (f != to) begin
         f += (to > from) ? 1 : -1;
         push(EV_STEP, f, d, TC);
      end
   endtask

   task automatic serve(int f);
      push(EV_DOPEN, f, 0, 0);
      push(EV_DCLOSE, f, 0, DC);
   endtask

   task automatic got(ev_kind_t k, int f, int d, int s);
      ev_t e;
      checks++;
      if (exp_q.size() == 0) begin
         errors++;
         $display("FAIL unexpected event: got %s floor=%0d dirs=%0d span=%0d, required none",
                  k.name(), f, d, s);
         return;
      end
      e = exp_q.pop_front();
      if (e.kind != k || e.floor != f || e.dirs != d || e.span != s) begin
         errors++;
         $display("FAIL event: got %s floor=%0d dirs=%0d span=%0d, required %s floor=%0d dirs=%0d span=%0d",
                  k.name(), f, d, s, e.kind.name(), e.floor, e.dirs, e.span);
      end
   endtask

   // Monitor
   initial begin
      int         cyc;
      int         mark;
      int         door_t;
      logic [2:0] p_floor;
      logic       p_door, p_idle, p_estop, p_moving;
      cyc = 0; mark = 0; door_t = 0;
      p_floor = '0; p_door = 0; p_idle = 1; p_estop = 0; p_moving = 0;
      forever begin
         @(negedge clk);
         cyc++;
         if (!reset) begin
            if (bus.moving && !p_moving) mark = cyc;
            if (!bus.door_open && p_door)
               got(EV_DCLOSE, int'(bus.current_floor), 0, cyc - door_t);
            if (bus.current_floor != p_floor) begin
               got(EV_STEP, int'(bus.current_floor), {bus.dir_up, bus.dir_down}, cyc - mark);
               mark = cyc;
            end
            if (bus.door_open && !p_door) begin
               got(EV_DOPEN, int'(bus.current_floor), 0, 0);
               door_t = cyc;
            end
            if (bus.idle && !p_idle)
               got(EV_IDLE, int'(bus.current_floor), {bus.dir_up, bus.dir_down}, 0);
            if (bus.estop_active && !p_estop)
               got(EV_ESTOP, int'(bus.current_floor), {bus.dir_up, bus.dir_down}, 0);
         end
         p_floor  = bus.current_floor;
         p_door   = bus.door_open;
         p_idle   = bus.idle;
         p_estop  = bus.estop_active;
         p_moving = bus.moving;
      end
   end

   task automatic req(int f);
      bus.req_valid = 1'b1;
      bus.req_floor = 3'(f);
      @(negedge clk);
      bus.req_valid = 1'b0;
   endtask

   task automatic wait_floor(int f);
      int n;
      n = 0;
      while (int'(bus.current_floor) != f && n < 200) begin
         @(negedge clk);
         n++;
      end
      chk($sformatf("reach floor %0d within budget", f), int'(n < 200), 1);
   endtask

   task automatic wait_door();
      int n;
      n = 0;
      while (!bus.door_open && n < 50) begin
         @(negedge clk);
         n++;
      end
      chk("door opens within budget", int'(n < 50), 1);
   endtask

   task automatic wait_drain();
      int n;
      n = 0;
      while (!(exp_q.size() == 0 && bus.idle) && n < 400) begin
         @(negedge clk);
         n++;
      end
      chk("expected events drained", exp_q.size(), 0);
   endtask

   initial begin
      #1000000;
      $display("FAIL watchdog expired");
      $fatal(1);
   end

   initial begin
      bus.req_valid = 0;  bus.req_floor = '0;  bus.emergency_stop = 1;
      bus6.req_valid = 0; bus6.req_floor = '0; bus6.emergency_stop = 1;
      reset = 1;
      repeat (3) @(negedge clk);
      // reset overrides a held emergency_stop
      chk("reset idle", bus.idle, 1);
      chk("reset estop_active", bus.estop_active, 0);
      chk("reset current_floor", bus.current_floor, 0);
      chk("reset pending", bus.pending, 0);
      chk("reset dirs", {bus.dir_up, bus.dir_down}, 0);
      chk("reset moving", bus.moving, 0);
      chk("reset door_open", bus.door_open, 0);
      chk("reset req_reject", bus.req_reject, 0);
      bus.emergency_stop = 0;
      bus6.emergency_stop = 0;
      @(negedge clk);
      reset = 0;
      @(negedge clk);

      // out-of-range requests on a 6-floor car
      bus6.req_valid = 1; bus6.req_floor = 3'd7;
      @(negedge clk);
      chk("reject floor 7 pulse", bus6.req_reject, 1);
      chk("reject floor 7 pending", bus6.pending, 0);
      bus6.req_floor = 3'd6;
      @(negedge clk);
      chk("reject floor 6 pulse", bus6.req_reject, 1);
      bus6.req_floor = 3'd5;
      @(negedge clk);
      bus6.req_valid = 0;
      chk("accept floor 5 no reject", bus6.req_reject, 0);
      chk("accept floor 5 pending", bus6.pending, 6'h20);
      @(negedge clk);
      chk("reject idle after pulse", bus6.req_reject, 0);

      // 1: 0 -> 5
      push_steps(0, 5); serve(5); push(EV_IDLE, 5, 0, 0);
      req(5);
      chk("t1 pending latched", bus.pending, 8'h20);
      chk("t1 still idle", bus.idle, 1);
      @(negedge clk);
      chk("t1 moving", bus.moving, 1);
      chk("t1 dirs up", {bus.dir_up, bus.dir_down}, 2);
      wait_drain();
      chk("t1 pending cleared", bus.pending, 0);
      chk("t1 dirs cleared", {bus.dir_up, bus.dir_down}, 0);

      // 2: return to 0, then 6 with 3 picked up on the way
      push_steps(5, 0); serve(0); push(EV_IDLE, 0, 0, 0);
      req(0);
      wait_drain();
      push_steps(0, 3); serve(3); push_steps(3, 6); serve(6); push(EV_IDLE, 6, 0, 0);
      req(6);
      wait_floor(1);
      req(3);
      wait_drain();

      // 3: 6 -> 2, then up to 7 with a call to 1 placed at floor 4
      push_steps(6, 2); serve(2); push(EV_IDLE, 2, 0, 0);
      req(2);
      wait_drain();
      push_steps(2, 7); serve(7); push_steps(7, 1); serve(1); push(EV_IDLE, 1, 0, 0);
      req(7);
      wait_floor(4);
      req(1);
      wait_drain();

      // 4: e-stop between floors 2 and 3 while heading to 4
      push_steps(1, 2); push(EV_ESTOP, 2, 2, 0); push(EV_IDLE, 2, 2, 0);
      push_steps(2, 4); serve(4); push_steps(4, 6); serve(6); push(EV_IDLE, 6, 0, 0);
      req(4);
      wait_floor(2);
      bus.emergency_stop = 1;
      @(negedge clk);
      chk("t4 estop_active", bus.estop_active, 1);
      chk("t4 floor held", bus.current_floor, 2);
      chk("t4 door closed", bus.door_open, 0);
      req(6);
      chk("t4 pending during estop", bus.pending, 8'h50);
      repeat (3) @(negedge clk);
      chk("t4 still held", bus.current_floor, 2);
      bus.emergency_stop = 0;
      @(negedge clk);
      chk("t4 idle after release", bus.idle, 1);
      @(negedge clk);
      chk("t4 resumes moving", bus.moving, 1);
      wait_drain();

      // 5: repeat call at the open-door floor extends the dwell
      push(EV_DOPEN, 6, 0, 0); push(EV_DCLOSE, 6, 0, 5); push(EV_IDLE, 6, 0, 0);
      req(6);
      wait_door();
      @(negedge clk);
      req(6);
      chk("t5 bit stays clear", bus.pending, 0);
      chk("t5 door still open", bus.door_open, 1);
      wait_drain();

      // 6: long idle at floor 6
`ifdef LIFT_PARKING_EN
      push_steps(6, 0); push(EV_IDLE, 0, 0, 0);
      repeat (60) @(negedge clk);
      chk("t6 parked floor", bus.current_floor, 0);
`else
      repeat (60) @(negedge clk);
      chk("t6 stays at floor", bus.current_floor, 6);
`endif
      chk("t6 idle", bus.idle, 1);
      chk("t6 door closed", bus.door_open, 0);
      chk("final queue empty", exp_q.size(), 0);

      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end
endmodule
